// File: rtl/result_unloader_pkg.sv
// rtl/result_unloader_pkg.sv - shared types and helpers for matrix-multiplier result consumers
//
// Purpose: FSM state type, default geometry constants and the flat-vector
// element-select helpers reused by every reader of the multiplier result.
package result_unloader_pkg;

  // Default geometry (4x4 matrix of 32-bit elements).
  localparam int unsigned ROW_DEF   = 4;
  localparam int unsigned COL_DEF   = 4;
  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned N_ELEM    = ROW_DEF * COL_DEF;
  localparam int unsigned IDX_W     = $clog2(N_ELEM);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Index counter width; a single-element result still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of element k (k = r*COL + c) inside the flat result vector.
  function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - captures the multiplier result and streams it out element by element
//
// Purpose: on a rising edge of done_in, snapshot result_in into a shadow
// register and stream its ROW*COL elements (k = 0 first) over a valid/ready
// handshake, freeing the multiplier immediately after capture.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   done_in     multiplier done level; rising edge marks a new result
//   result_in   flat ROW*COL*WIDTH result vector
//   out_data    current element
//   out_valid   out_data valid
//   out_ready   consumer accepts the beat
//   out_last    current beat is element N-1
//   out_index   element index of current beat
//   busy        result captured and not fully drained
//   drain_done  one-cycle pulse after the final beat is accepted
//   overrun     sticky: a done edge arrived while streaming and was dropped
module result_unloader
  import result_unloader_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int ROW   = 4,
  parameter  int COL   = 4,
  localparam int N     = ROW * COL,
  localparam int IW    = idx_width(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_in,
  input  logic [N*WIDTH-1:0]       result_in,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [IW-1:0]            out_index,
  output logic                     busy,
  output logic                     drain_done,
  output logic                     overrun
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e           state_q;
  logic             done_q;
  logic [IW-1:0]    idx_q;
  logic             valid_q;
  logic             busy_q;
  logic             drain_done_q;
  logic             overrun_q;
  logic [WIDTH-1:0] shadow_q [N];

  logic done_edge;
  logic xfer;
  logic at_last;

  assign done_edge = done_in & ~done_q;
  assign xfer      = valid_q & out_ready;
  assign at_last   = (idx_q == LAST_IDX);

  // Data, index and last all derive from registers only, so they hold
  // stable across stalls without any extra enable logic.
  assign out_data   = shadow_q[idx_q];
  assign out_index  = idx_q;
  assign out_last   = valid_q & at_last;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign drain_done = drain_done_q;
  assign overrun    = overrun_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      // Held high so a done level already asserted out of reset is not an edge.
      done_q       <= 1'b1;
      idx_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < N; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      done_q       <= done_in;
      drain_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (done_edge) begin
            for (int k = 0; k < N; k++) begin
              shadow_q[k] <= result_in[elem_lsb(k, WIDTH) +: WIDTH];
            end
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end

        SEND: begin
          if (xfer && at_last) begin
            drain_done_q <= 1'b1;
            idx_q        <= '0;
            if (done_edge) begin
              // Next result lands exactly as the previous one finishes:
              // recapture and keep streaming with no bubble.
              for (int k = 0; k < N; k++) begin
                shadow_q[k] <= result_in[elem_lsb(k, WIDTH) +: WIDTH];
              end
            end else begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            if (xfer) begin
              idx_q <= idx_q + 1'b1;
            end
            // The shadow is still in use, so a new result cannot be taken.
            if (done_edge) begin
              overrun_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - directed self-checking bench for result_unloader
module tb_result_unloader;

  localparam int WIDTH = 32;
  localparam int ROW   = 4;
  localparam int COL   = 4;
  localparam int N     = ROW * COL;
  localparam int IW    = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 done_in;
  logic [N*WIDTH-1:0]   result_in;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [IW-1:0]        out_index;
  logic                 busy;
  logic                 drain_done;
  logic                 overrun;

  int vec_cnt = 0;
  int err_cnt = 0;

  result_unloader #(.WIDTH(WIDTH), .ROW(ROW), .COL(COL)) dut (
    .clk        (clk),
    .rst        (rst),
    .done_in    (done_in),
    .result_in  (result_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_index  (out_index),
    .busy       (busy),
    .drain_done (drain_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int k = 0; k < N; k++) result_in[k*WIDTH +: WIDTH] = base + 32'(k);
  endtask

  // Present a fresh result and produce a clean done rising edge.
  task automatic start(input logic [31:0] base);
    fill(base);
    done_in = 1'b0;
    step();
    done_in = 1'b1;
    step();
    chk_eq("start_valid", 64'(out_valid), 64'd1);
    chk_eq("start_busy", 64'(busy), 64'd1);
  endtask

  // Drain one stream, checking every beat. bp selects ready pattern 1,0,0,1;
  // edge_at raises done at that beat (with new data nb); scramble overwrites
  // result_in right after capture.
  task automatic drain(input logic [31:0] base, input bit bp, input int edge_at,
                       input logic [31:0] nb, input bit scramble);
    int k;
    int cyc;
    bit rdy;
    k = 0;
    cyc = 0;
    while (k < N && cyc < 200) begin
      case (cyc % 4)
        1, 2:    rdy = !bp;
        default: rdy = 1'b1;
      endcase
      out_ready = rdy;
      chk_eq("beat_valid", 64'(out_valid), 64'd1);
      chk_eq("beat_index", 64'(out_index), 64'(k));
      chk_eq("beat_data", 64'(out_data), 64'(base + 32'(k)));
      chk_eq("beat_last", 64'(out_last), 64'(k == N - 1));
      chk_eq("beat_busy", 64'(busy), 64'd1);
      if (cyc != 0) chk_eq("beat_drain_low", 64'(drain_done), 64'd0);
      if (edge_at == k && rdy) begin
        fill(nb);
        done_in = 1'b1;
      end
      if (rdy) k++;
      step();
      if (scramble && cyc == 0) result_in = '1;
      cyc++;
    end
    chk_eq("drain_count", 64'(k), 64'(N));
  endtask

  initial begin
    rst       = 1'b0;
    done_in   = 1'b0;
    out_ready = 1'b0;
    result_in = '0;
    step();
    step();
    chk_eq("rst_valid", 64'(out_valid), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_last", 64'(out_last), 64'd0);
    chk_eq("rst_drain", 64'(drain_done), 64'd0);
    chk_eq("rst_overrun", 64'(overrun), 64'd0);
    chk_eq("rst_index", 64'(out_index), 64'd0);
    chk_eq("rst_data", 64'(out_data), 64'd0);
    rst = 1'b1;
    step();

    // Basic drain with ready held high.
    start(32'h1000_0000);
    drain(32'h1000_0000, 1'b0, -1, 32'h0, 1'b0);
    chk_eq("basic_end_valid", 64'(out_valid), 64'd0);
    chk_eq("basic_end_busy", 64'(busy), 64'd0);
    chk_eq("basic_drain_pulse", 64'(drain_done), 64'd1);
    step();
    chk_eq("basic_drain_single", 64'(drain_done), 64'd0);
    chk_eq("basic_overrun", 64'(overrun), 64'd0);

    // Backpressure plus result_in changing after capture; ready ignored in IDLE.
    out_ready = 1'b1;
    start(32'h1000_0000);
    drain(32'h1000_0000, 1'b1, -1, 32'h0, 1'b1);
    chk_eq("bp_end_valid", 64'(out_valid), 64'd0);
    chk_eq("bp_drain_pulse", 64'(drain_done), 64'd1);

    // Back-to-back: new edge on the k=15 transfer.
    out_ready = 1'b1;
    start(32'h1000_0000);
    done_in = 1'b0;
    drain(32'h1000_0000, 1'b0, N - 1, 32'h2000_0000, 1'b0);
    chk_eq("b2b_valid", 64'(out_valid), 64'd1);
    chk_eq("b2b_index", 64'(out_index), 64'd0);
    chk_eq("b2b_data", 64'(out_data), 64'h2000_0000);
    chk_eq("b2b_drain_pulse", 64'(drain_done), 64'd1);
    chk_eq("b2b_overrun", 64'(overrun), 64'd0);
    drain(32'h2000_0000, 1'b0, -1, 32'h0, 1'b0);
    chk_eq("b2b_end_valid", 64'(out_valid), 64'd0);
    chk_eq("b2b_overrun_end", 64'(overrun), 64'd0);

    // Overrun: edge at beat 5 with different data is dropped.
    start(32'h1000_0000);
    done_in = 1'b0;
    drain(32'h1000_0000, 1'b0, 5, 32'h3000_0000, 1'b0);
    chk_eq("ovr_flag", 64'(overrun), 64'd1);
    chk_eq("ovr_end_valid", 64'(out_valid), 64'd0);
    step();
    step();
    chk_eq("ovr_no_second", 64'(out_valid), 64'd0);
    chk_eq("ovr_sticky", 64'(overrun), 64'd1);

    // Reset mid-stream at beat 7, with done_in left high afterwards.
    start(32'h1000_0000);
    for (int k = 0; k < 7; k++) step();
    chk_eq("mid_index_pre", 64'(out_index), 64'd7);
    rst = 1'b0;
    step();
    chk_eq("mid_valid", 64'(out_valid), 64'd0);
    chk_eq("mid_busy", 64'(busy), 64'd0);
    chk_eq("mid_index", 64'(out_index), 64'd0);
    chk_eq("mid_overrun", 64'(overrun), 64'd0);
    rst = 1'b1;
    step();
    step();
    step();
    chk_eq("mid_no_restart", 64'(out_valid), 64'd0);
    start(32'h4000_0000);
    drain(32'h4000_0000, 1'b0, -1, 32'h0, 1'b0);
    chk_eq("mid_end_drain", 64'(drain_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Reader at the output end of the matrix multiplier.
- Captures the flat ROW*COL*WIDTH result vector when the multiplier signals done.
- Streams the vector out one WIDTH-bit element per accepted beat over a valid/ready handshake, with index and last markers.
- Frees the multiplier for the next run as soon as capture completes; also flags dropped results.

Parameters:
- WIDTH, 32, element width in bits
- ROW, 4, result rows
- COL, 4, result columns

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the clk edge)
- done_in  in  1  multiplier Done, level; rising edge marks a new result
- result_in  in  ROW*COL*WIDTH  multiplier result_out vector
- out_data  out  WIDTH  current element
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the beat
- out_last  out  1  current beat is element ROW*COL-1
- out_index  out  $clog2(ROW*COL)  element index k of current beat
- busy  out  1  high while a result is captured and not fully drained
- drain_done  out  1  one-cycle pulse after the final beat is accepted
- overrun  out  1  sticky: a done edge was dropped

Behaviour:
- Constants: N = ROW*COL; element k = result_in[k*WIDTH +: WIDTH]; k = r*COL + c (row-major); k=0 is sent first.
- Reset values (rst=0):
  - out_valid, out_last, busy, drain_done, overrun = 0
  - out_data, out_index = 0; state = IDLE
  - done_q = 1, so a Done already high coming out of reset is not taken as an edge
- Edge detect: done_q <= done_in every cycle; edge = done_in & ~done_q.
- Handshake:
  - A beat transfers when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- FSM IDLE:
  - On edge: latch result_in into a shadow register, index=0, go to SEND.
  - out_valid=1 and busy=1 in the next cycle. Capture latency is 1 cycle from the sampled edge to the first valid beat.
- FSM SEND:
  - out_data = shadow[index]; out_last = (index == N-1).
  - Transfer with index < N-1: index+1.
  - Transfer with index == N-1:
    - If edge in the same cycle: re-latch result_in, index=0, stay in SEND (back-to-back, no bubble). drain_done still pulses.
    - Otherwise: go to IDLE; out_valid=0, busy=0, drain_done=1 in the next cycle.
  - Edge in any other SEND cycle: overrun <= 1 (sticky until reset). Edge dropped; shadow unchanged; stream continues.
- Timing rules:
  - result_in is sampled only in the capture cycle; later changes do not affect the stream.
  - out_ready is ignored in IDLE.
  - Minimum drain time = N cycles with out_ready held high.
- Reset mid-stream: the stream is aborted, all outputs take reset values, and the shadow contents are discarded.
- Widths:
  - out_index wraps only via the explicit reset to 0. It never passes N-1.
  - For N a power of two the index counter is exactly $clog2(N) bits. For other N the compare against N-1 terminates the stream.

Decomposition:
- Shared package:
  - N_ELEM = ROW*COL
  - IDX_W = $clog2(N_ELEM)
  - state enum {IDLE, SEND}
  - Element-select function (k -> bit slice), reused by other result consumers.
- Single module. The shadow register plus mux is inline; no sub-module is warranted.

Test Plan:
- Basic drain: result_in element k = 32'h1000_0000+k; done_in rises, out_ready=1 → 16 beats, out_index 0..15, out_data 32'h1000_0000..32'h1000_000F, out_last only on k=15, drain_done pulse one cycle after, busy low.
- Backpressure: out_ready toggles 1,0,0,1 repeating → every beat appears exactly once in order; data and index stable during stalls; total 16 transfers.
- Input change after capture: change result_in to all 32'hFFFF_FFFF one cycle after the edge → stream still carries 32'h1000_0000+k values.
- Overrun: second done edge at beat 5 → overrun=1 and stays 1; stream still ends at k=15 with the original data; no second stream.
- Back-to-back: second done edge coincides with the k=15 transfer, new data 32'h2000_0000+k → next cycle out_valid=1, index 0, data 32'h2000_0000; overrun stays 0.
- Reset: rst=0 at beat 7 → next cycle out_valid=0, busy=0, index=0. done_in still high after rst=1 → no new stream until done_in falls and rises again.
